// File: rtl/tx_gearbox_multiwidth.sv
// 64b/66b TX gearbox: packs 66-bit blocks, delivered as DATA_WIDTH-bit beats, into a
// continuous DATA_WIDTH-bit serializer stream with one pause slot per 33 slots.
`timescale 1ns/1ps

module tx_gearbox_multiwidth #(
    parameter int DATA_WIDTH = 32,
    parameter int HDR_WIDTH  = 2,
    parameter int TRDY_LEAD  = 6
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic [DATA_WIDTH-1:0] i_rx_data,
    input  logic [HDR_WIDTH-1:0]  i_rx_sync_hdr,
    input  logic                  i_rx_data_valid,
    output logic                  o_tx_trdy,
    output logic [DATA_WIDTH-1:0] o_tx_data,
    output logic                  o_tx_valid,
    output logic                  o_overrun,
    output logic                  o_underrun
);

    localparam int BPB    = 64 / DATA_WIDTH;
    localparam int BEAT_W = (BPB > 1) ? $clog2(BPB) : 1;
    localparam int BUF_W  = 2 * DATA_WIDTH + HDR_WIDTH;
    localparam int RES_W  = $clog2(BUF_W + 1);

    localparam logic [5:0]        LAST_SLOT = 6'd32;
    localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BPB - 1);

    typedef enum logic [1:0] {
        SLOT_IDLE,
        SLOT_DATA,
        SLOT_PAUSE,
        SLOT_FREEZE
    } slot_e;

    logic [5:0]            r_seq_cnt;
    logic [BEAT_W-1:0]     r_beat_cnt;
    logic [BUF_W-1:0]      r_buf;
    logic [RES_W-1:0]      r_res;
    logic                  r_started;
    logic                  r_tx_trdy;
    logic [DATA_WIDTH-1:0] r_tx_data;
    logic                  r_tx_valid;
    logic                  r_overrun;
    logic                  r_underrun;

    slot_e                 w_slot;
    logic [BUF_W-1:0]      w_chunk;
    logic [BUF_W-1:0]      w_src;
    logic [RES_W-1:0]      w_add_len;
    logic [RES_W-1:0]      w_src_len;
    logic [RES_W-1:0]      w_res_next;
    logic [5:0]            w_seq_next;
    logic [BEAT_W-1:0]     w_beat_next;
    logic [6:0]            w_lead_sum;
    logic [6:0]            w_lead_slot;
    logic                  w_trdy_next;

    // Before the first beat the slot counter is parked at 0, so a beat is always a data slot.
    always_comb begin
        w_slot = SLOT_IDLE;
        if (r_started && r_seq_cnt == LAST_SLOT) begin
            w_slot = SLOT_PAUSE;
        end else if (i_rx_data_valid) begin
            w_slot = SLOT_DATA;
        end else if (r_started) begin
            w_slot = SLOT_FREEZE;
        end
    end

    // NOTE: every signal gets a default before any branch so no path leaves it unassigned (no latch).
    always_comb begin
        w_chunk   = '0;
        w_add_len = RES_W'(DATA_WIDTH);
        w_src     = r_buf;
        w_src_len = r_res;
        if (r_beat_cnt == '0) begin
            w_chunk[HDR_WIDTH +: DATA_WIDTH] = i_rx_data;
            w_chunk[HDR_WIDTH-1:0]           = i_rx_sync_hdr;
            w_add_len                        = RES_W'(DATA_WIDTH + HDR_WIDTH);
        end else begin
            w_chunk[DATA_WIDTH-1:0] = i_rx_data;
        end
        if (w_slot != SLOT_PAUSE) begin
            w_src     = r_buf | (w_chunk << r_res);
            w_src_len = r_res + w_add_len;
        end
        w_res_next = (w_src_len >= RES_W'(DATA_WIDTH)) ? w_src_len - RES_W'(DATA_WIDTH) : '0;
    end

    always_comb begin
        w_seq_next  = r_seq_cnt;
        w_beat_next = r_beat_cnt;
        if (w_slot == SLOT_DATA || w_slot == SLOT_PAUSE) begin
            w_seq_next = (r_seq_cnt == LAST_SLOT) ? 6'd0 : r_seq_cnt + 6'd1;
        end
        if (w_slot == SLOT_DATA) begin
            w_beat_next = (r_beat_cnt == BEAT_LAST) ? '0 : r_beat_cnt + BEAT_W'(1);
        end
        w_lead_sum  = {1'b0, w_seq_next} + 7'(TRDY_LEAD);
        w_lead_slot = (w_lead_sum >= 7'd33) ? w_lead_sum - 7'd33 : w_lead_sum;
        w_trdy_next = (w_lead_slot != 7'd32);
    end

    // NOTE: the residual buffer is reset too; stale bits would otherwise be OR-merged into the next block.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_seq_cnt  <= '0;
            r_beat_cnt <= '0;
            r_buf      <= '0;
            r_res      <= '0;
            r_started  <= 1'b0;
            r_tx_trdy  <= 1'b1;
            r_tx_data  <= '0;
            r_tx_valid <= 1'b0;
            r_overrun  <= 1'b0;
            r_underrun <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            r_seq_cnt  <= w_seq_next;
            r_beat_cnt <= w_beat_next;
            r_tx_trdy  <= w_trdy_next;
            r_overrun  <= (w_slot == SLOT_PAUSE) && i_rx_data_valid;
            r_underrun <= (w_slot == SLOT_FREEZE);
            r_tx_valid <= (w_slot == SLOT_DATA) || (w_slot == SLOT_PAUSE);
            if (w_slot == SLOT_DATA || w_slot == SLOT_PAUSE) begin
                r_started <= 1'b1;
                r_buf     <= w_src >> DATA_WIDTH;
                r_res     <= w_res_next;
                r_tx_data <= w_src[DATA_WIDTH-1:0];
            end
        end
    end

    assign o_tx_trdy  = r_tx_trdy;
    assign o_tx_data  = r_tx_data;
    assign o_tx_valid = r_tx_valid;
    assign o_overrun  = r_overrun;
    assign o_underrun = r_underrun;

endmodule
